// File: rtl/dmem_responder_if.sv
// MEM-stage bus between the datapath (master) and the data-memory
// responder (slave): request fields flow toward memory, load data,
// stall and fault information flow back.
interface dmem_responder_if;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic [31:0] rdataM;
  logic        stallM;
  logic        misalignM;
  logic        fault_flag;
  logic [31:0] fault_addr;

  // Datapath side: issues requests, observes results.
  modport master (
    output memreadM, memwriteM, addrM, wdataM,
    input  rdataM, stallM, misalignM, fault_flag, fault_addr
  );

  // Memory side: consumes requests, produces results.
  modport slave (
    input  memreadM, memwriteM, addrM, wdataM,
    output rdataM, stallM, misalignM, fault_flag, fault_addr
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. An aligned
// request in IDLE is latched, the pipeline is stalled for LATENCY+1
// cycles, the array is accessed on the last stalled edge and the
// following DONE cycle releases the pipeline with rdataM valid.
// Misaligned requests never touch the array; they only record a sticky
// fault and the first offending address. LATENCY must be 1..15.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic                  read_q;
  logic [31:0]           rdata_q;
  logic                  fault_flag_q;
  logic [31:0]           fault_addr_q;

  logic [31:0]           mem_q [DEPTH];

  logic                  req;
  logic                  addr_lo_nz;
  logic                  idle_misalign;
  logic                  idle_accept;
  logic                  access;
  logic [DEPTH_LOG2-1:0] req_idx;

  // Address bits above the array index only wrap the address space.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addrM[31:DEPTH_LOG2+2];

  // Request decode; inputs only matter while the FSM sits in IDLE.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    req           = 1'b0;
    addr_lo_nz    = 1'b0;
    idle_misalign = 1'b0;
    idle_accept   = 1'b0;
    access        = 1'b0;
    req_idx       = bus.addrM[DEPTH_LOG2+1:2];
    req           = bus.memreadM | bus.memwriteM;
    addr_lo_nz    = (bus.addrM[1:0] != 2'b00);
    if (state_q == IDLE) begin
      idle_misalign = req & addr_lo_nz;
      idle_accept   = req & ~addr_lo_nz;
    end
    access = (state_q == BUSY) && (cnt_q == 4'd0);
  end

  // Control FSM with the latched request, load data and fault registers.
  // NOTE: sequential state uses non-blocking assignments, so the load below reads the array word as it was before a same-edge store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      rdata_q      <= 32'd0;
      fault_flag_q <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (idle_accept) begin
            idx_q   <= req_idx;
            wdata_q <= bus.wdataM;
            write_q <= bus.memwriteM;
            read_q  <= bus.memreadM;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end else if (idle_misalign) begin
            // Only the first misaligned address since reset is kept.
            if (!fault_flag_q) begin
              fault_addr_q <= bus.addrM;
            end
            fault_flag_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // A pure store leaves the previous load data visible.
            if (read_q) begin
              rdata_q <= mem_q[idx_q];
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // The pipeline moves past the request at the end of this cycle.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Array write port; reset only abandons the pending access via the FSM.
  // NOTE: the storage array is deliberately left without a reset so it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (access && write_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // The stall falls asynchronously with reset through the rst term.
  assign bus.stallM     = rst & (idle_accept | (state_q == BUSY));
  assign bus.misalignM  = idle_misalign;
  assign bus.rdataM     = rdata_q;
  assign bus.fault_flag = fault_flag_q;
  assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. The driver computes each
// request's expected outcome from a word-array reference model and
// queues it; a monitor pops and compares whenever the DUT ends a stall
// (DONE cycle) or flags a misaligned request.
module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 8;
  localparam int LAT        = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic rst;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_mis;
    logic [31:0] rdata;
    logic        fflag;
    logic [31:0] faddr;
  } entry_t;

  entry_t      sb[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;
  logic        ref_fflag;
  logic [31:0] ref_faddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b0;
    bus.addrM     = 32'd0;
    bus.wdataM    = 32'd0;
  endtask

  // Random bus noise while the responder is busy; it must be ignored.
  task automatic drive_noise();
    bus.memreadM  = 1'($urandom_range(0, 1));
    bus.memwriteM = 1'($urandom_range(0, 1));
    bus.addrM     = $urandom;
    bus.wdataM    = $urandom;
  endtask

  // Issue one request at a negedge; returns at the negedge of the cycle
  // in which the next request may be presented.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    entry_t e;
    int     idx;
    bus.memreadM  = rd;
    bus.memwriteM = wr;
    bus.addrM     = a;
    bus.wdataM    = wd;
    if (!(rd | wr)) begin
      @(negedge clk);
    end else if (a[1:0] != 2'b00) begin
      if (!ref_fflag) ref_faddr = a;
      ref_fflag = 1'b1;
      e = '{is_mis: 1'b1, rdata: ref_rdata, fflag: ref_fflag, faddr: ref_faddr};
      sb.push_back(e);
      @(negedge clk);
    end else begin
      idx = int'(a / 4) % DEPTH;
      if (rd) ref_rdata = ref_mem[idx];
      if (wr) ref_mem[idx] = wd;
      e = '{is_mis: 1'b0, rdata: ref_rdata, fflag: ref_fflag, faddr: ref_faddr};
      sb.push_back(e);
      @(negedge clk);
      repeat (LAT + 1) begin
        drive_noise();
        @(negedge clk);
      end
    end
    drive_idle();
  endtask

  // Monitor: samples mid-low-phase, pops expectations on DUT events.
  initial begin : monitor
    int          stall_run;
    logic        fchk;
    entry_t      fexp;
    entry_t      e;
    stall_run = 0;
    fchk      = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        stall_run = 0;
        fchk      = 1'b0;
        sb.delete();
      end else begin
        if (fchk) begin
          check("fault_flag", 32'(bus.fault_flag), 32'(fexp.fflag));
          check("fault_addr", bus.fault_addr, fexp.faddr);
          fchk = 1'b0;
        end
        if (bus.stallM) begin
          stall_run++;
        end else if (stall_run > 0) begin
          if (sb.size() == 0) begin
            check("orphan_done", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("done_kind", 32'(e.is_mis), 32'd0);
            check("stall_cycles", 32'(stall_run), 32'(LAT + 1));
            check("rdata", bus.rdataM, e.rdata);
            check("done_fault_flag", 32'(bus.fault_flag), 32'(e.fflag));
          end
          stall_run = 0;
        end
        if (bus.misalignM) begin
          if (sb.size() == 0) begin
            check("orphan_misalign", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("mis_kind", 32'(e.is_mis), 32'd1);
            check("mis_stall", 32'(bus.stallM), 32'd0);
            check("mis_rdata", bus.rdataM, e.rdata);
            fexp = e;
            fchk = 1'b1;
          end
        end
      end
    end
  end

  initial begin : driver
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    rst       = 1'b0;
    ref_rdata = 32'd0;
    ref_fflag = 1'b0;
    ref_faddr = 32'd0;
    // Aligned store held during reset must not raise the stall.
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b1;
    bus.addrM     = 32'h40;
    bus.wdataM    = 32'h1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.stallM), 32'd0);
    check("rst_rdata", bus.rdataM, 32'd0);
    check("rst_fault_flag", 32'(bus.fault_flag), 32'd0);
    check("rst_fault_addr", bus.fault_addr, 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);

    // Fill the whole array so every later load has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b0, 1'b1, 32'(i * 4), $urandom);
    end

    // Store then load, back-to-back loads.
    do_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h40, 32'h0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0);
    do_req(1'b1, 1'b0, 32'h44, 32'h0);
    // Misaligned loads: first address sticks.
    do_req(1'b1, 1'b0, 32'h42, 32'h0);
    do_req(1'b1, 1'b0, 32'h47, 32'h0);
    // Store with simultaneous load returns the pre-write word.
    do_req(1'b0, 1'b1, 32'h10, 32'h1);
    do_req(1'b1, 1'b1, 32'h10, 32'h2);
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    // Address wrap.
    do_req(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    do_req(1'b1, 1'b0, 32'h000, 32'h0);

    // Reset in the middle of a store: access abandoned.
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b1;
    bus.addrM     = 32'h80;
    bus.wdataM    = 32'h12345678;
    @(negedge clk);
    drive_idle();
    #1;
    check("busy_stall", 32'(bus.stallM), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(bus.stallM), 32'd0);
    check("midrst_rdata", bus.rdataM, 32'd0);
    check("midrst_fault_flag", 32'(bus.fault_flag), 32'd0);
    ref_rdata = 32'd0;
    ref_fflag = 1'b0;
    ref_faddr = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h80, 32'h0);

    // Randomized traffic with idle gaps and misaligned requests.
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 9));
      a = $urandom;
      a[1:0] = 2'b00;
      d = $urandom;
      if (k <= 3)      do_req(1'b1, 1'b0, a, d);
      else if (k <= 6) do_req(1'b0, 1'b1, a, d);
      else if (k == 7) do_req(1'b1, 1'b1, a, d);
      else if (k == 8) begin
        a[1:0] = 2'($urandom_range(1, 3));
        do_req(1'($urandom_range(0, 1)), 1'b1, a, d);
      end else         do_req(1'b0, 1'b0, a, d);
    end

    drive_idle();
    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the pipeline's MEM stage. It accepts the word-aligned load/store request presented by the datapath (ALU result as address, forwarded store data) and holds the pipeline with a stall while the access completes over a programmable latency. It returns load data, flags misaligned accesses, and is the memory-side end of the datapath's MEM-stage interface.

## Interface
- DEPTH_LOG2, default 8: number of 32-bit words is 2^DEPTH_LOG2.
- LATENCY, default 2: wait cycles before the array access; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- memreadM  in  1  load request.
- memwriteM  in  1  store request.
- addrM  in  32  byte address.
- wdataM  in  32  store data.
- rdataM  out  32  load data, registered.
- stallM  out  1  hold the pipeline (stallF, stallD, stallE, stallM) while high.
- misalignM  out  1  combinational, current request has addrM[1:0] != 0.
- fault_flag  out  1  sticky misalign indicator.
- fault_addr  out  32  address of the first misaligned request since reset.

## Operation
- req = memreadM | memwriteM. A store has priority when both are high.
- Word index = addrM[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).
- The array is not reset and its contents survive a reset.
- States are IDLE, BUSY and DONE.
- IDLE:
  - Aligned req: latch addr, wdata and the write bit; load cnt = LATENCY-1; go to BUSY.
  - Misaligned req: no array access and no state change. fault_addr is captured only if fault_flag = 0. fault_flag is set to 1.
- BUSY:
  - While cnt != 0, decrement cnt.
  - When cnt == 0, perform the access on this edge.
  - Store: array[idx] <= latched wdata.
  - Load: rdataM <= array[idx].
  - Store with simultaneous load: rdataM <= pre-write contents.
  - Pure store: rdataM is unchanged.
  - Go to DONE.
- DONE: always go to IDLE. Inputs are ignored in this state, because the pipeline advances past the request at the end of this cycle.
- Inputs are ignored in BUSY and DONE. Only the latched copies are used.
- stallM = rst & ((state == IDLE & req & ~misalignM) | state == BUSY).
- misalignM = req & (addrM[1:0] != 0). It is meaningful only in IDLE and forced to 0 in BUSY and DONE.
- A misaligned load leaves rdataM unchanged.

## Timing
- Reset values (asynchronous, rst = 0): state IDLE, cnt 0, rdataM 0, fault_flag 0, fault_addr 0, stallM 0.
- An aligned request arriving in IDLE at cycle t:
  - stallM is high for cycles t .. t+LATENCY, i.e. LATENCY+1 cycles.
  - The array access occurs on the edge ending cycle t+LATENCY.
  - Cycle t+LATENCY+1 is DONE: stallM = 0 and rdataM is valid.
- A back-to-back request presented in the cycle after DONE starts at IDLE with no dead cycle. Occupancy per access is LATENCY+2 cycles.
- Misaligned request: stallM stays 0 and the pipeline advances the same cycle. fault_flag and fault_addr update on the next edge.
- Reset mid-BUSY:
  - Pending access is abandoned and no array write occurs.
  - stallM drops asynchronously with rst.
  - After release the FSM is in IDLE, and a request still present is re-accepted as new.
- rdataM holds its value until the next completed load.

## Test plan
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x40; stallM high 3 cycles.
  - Load 0x40; stallM high 3 cycles, then rdataM = 0xDEADBEEF in DONE.
- Back-to-back loads of 0x40 and 0x44:
  - Second request starts the cycle after first DONE.
  - Total 8 cycles; both rdataM values correct in their DONE cycles.
- Misaligned load at 0x42:
  - Same cycle: misalignM = 1, stallM = 0.
  - Next edge: fault_flag = 1, fault_addr = 0x42.
  - Subsequent misaligned 0x47: fault_addr stays 0x42.
  - rdataM unchanged.
- Reset pulse during BUSY of a store of 0x12345678 to 0x80:
  - stallM goes 0 immediately; rdataM = 0.
  - After release, load 0x80 returns the old contents, not 0x12345678.
- Simultaneous memreadM = memwriteM = 1, addr 0x10, old 0x1, wdata 0x2:
  - rdataM = 0x1.
  - Subsequent load returns 0x2.
- Wrap with DEPTH_LOG2=8:
  - Store 0xA5A5A5A5 to 0x400.
  - Load 0x000 returns 0xA5A5A5A5.
